ddr_addr_gen_2d: RTL and testbench

Parametrised successor of the single-loop DDR read address generator. Issues DDR read requests over a 2-D strided region (outer loop × inner rows). Splits rows longer than MAX_BURST into chunks and limits in-flight beats with a credit counter. Tracks returned data beats, so done fires only when all data has arrived. One instance sits per DDR read channel, between ddr2pe_config and the DDR read-address port.

---
 rtl/ddr_addr_gen_2d.sv | 252 +++++++++++++++++++++++++
 tb/tb_ddr_addr_gen_2d.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_addr_gen_2d.sv
// Purpose : 2-D strided DDR read-address generator; splits rows into <=MAX_BURST chunks, limits beats in flight by credit, waits for all data.
// Latency : first request 1 cycle after start; done 1 cycle after the final counted beat (empty command: done 2 cycles after start).
// Backpr. : request held stable while ddr_addr_ready is low; new requests withheld while pending + size would exceed MAX_PEND_BEATS.
//
// Optional feature macro: DDR_ADDR_GEN_BOUNDARY_SPLIT_EN -- when defined, no request
// crosses a multiple of BOUNDARY_BEATS; when undefined, chunking is by MAX_BURST only.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   start               one-cycle command, taken only in IDLE (and not in the done cycle)
//   busy, done          busy outside IDLE; done is a one-cycle completion pulse
//   st_addr, burst, step, burst_num, outer_num, outer_step
//                       region description, latched on start (addresses in beats)
//   ddr_addr, ddr_size, ddr_addr_valid, ddr_addr_ready
//                       read-address request channel (valid/ready)
//   beat_valid, beat_ready
//                       monitor tap on the returned data channel
module ddr_addr_gen_2d #(
    parameter int DDR_ADDR_W     = 32,
    parameter int BURST_W        = 8,
    parameter int MAX_BURST      = 16,
    parameter int MAX_PEND_BEATS = 64,
    parameter int BOUNDARY_BEATS = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic [DDR_ADDR_W-1:0] st_addr,
    input  logic [BURST_W-1:0]    burst,
    input  logic [DDR_ADDR_W-1:0] step,
    input  logic [BURST_W-1:0]    burst_num,
    input  logic [BURST_W-1:0]    outer_num,
    input  logic [DDR_ADDR_W-1:0] outer_step,
    output logic [DDR_ADDR_W-1:0] ddr_addr,
    output logic [BURST_W-1:0]    ddr_size,
    output logic                  ddr_addr_valid,
    input  logic                  ddr_addr_ready,
    input  logic                  beat_valid,
    input  logic                  beat_ready
);

    localparam int PEND_W = $clog2(MAX_PEND_BEATS + 1);

    // Elaboration-time parameter sanity checks.
    if (MAX_BURST < 1 || MAX_BURST > (2 ** BURST_W) - 1) begin : g_chk_burst
        $error("MAX_BURST must be in 1 .. 2^BURST_W-1");
    end
    if (MAX_PEND_BEATS < MAX_BURST) begin : g_chk_pend
        $error("MAX_PEND_BEATS must be >= MAX_BURST");
    end
    if (BOUNDARY_BEATS < 1 || (BOUNDARY_BEATS & (BOUNDARY_BEATS - 1)) != 0) begin : g_chk_bnd
        $error("BOUNDARY_BEATS must be a power of 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Latched command
    logic [BURST_W-1:0]    burst_q;
    logic [BURST_W-1:0]    burst_num_q;
    logic [BURST_W-1:0]    outer_last_q;   // index of last outer iteration (outer_num 0 -> 0)
    logic [DDR_ADDR_W-1:0] step_q;
    logic [DDR_ADDR_W-1:0] outer_step_q;

    // Address accumulators: outer_base = st + o*outer_step, row_base = outer_base + r*step,
    // cur_addr = row_base + chunk_off. Stepped only on request accept.
    logic [DDR_ADDR_W-1:0] outer_base;
    logic [DDR_ADDR_W-1:0] row_base;
    logic [DDR_ADDR_W-1:0] cur_addr;
    logic [BURST_W-1:0]    chunk_off;
    logic [BURST_W-1:0]    row_cnt;
    logic [BURST_W-1:0]    outer_cnt;

    logic [PEND_W-1:0]     pending;
    logic [PEND_W-1:0]     pending_nxt;
    logic                  done_q;

    // Request shaping
    logic [BURST_W-1:0]    remain;
    logic [BURST_W-1:0]    req_size;
    logic [BURST_W-1:0]    next_chunk;
    logic                  credit_ok;
    logic                  req_accept;
    logic                  beat_cnt;
    logic                  start_acc;
    logic                  last_chunk;
    logic                  last_row;
    logic                  last_outer;
    logic                  last_req;

`ifdef DDR_ADDR_GEN_BOUNDARY_SPLIT_EN
    logic [DDR_ADDR_W-1:0] bnd_room;
`endif

    // ------------------------------------------------------------------
    // Request size and credit check
    // ------------------------------------------------------------------
    always_comb begin
        remain   = burst_q - chunk_off;
        req_size = (remain < BURST_W'(MAX_BURST)) ? remain : BURST_W'(MAX_BURST);
`ifdef DDR_ADDR_GEN_BOUNDARY_SPLIT_EN
        // Beats left before the next BOUNDARY_BEATS multiple; always >= 1.
        bnd_room = DDR_ADDR_W'(BOUNDARY_BEATS)
                 - (cur_addr & DDR_ADDR_W'(BOUNDARY_BEATS - 1));
        if (bnd_room < DDR_ADDR_W'(req_size)) begin
            req_size = BURST_W'(bnd_room);
        end
`endif
    end

    // The sum is formed wide so it cannot wrap before the compare.
    assign credit_ok  = (32'(pending) + 32'(req_size)) <= 32'(MAX_PEND_BEATS);

    // chunk_off + req_size never exceeds burst_q, so no overflow here.
    assign next_chunk = chunk_off + req_size;
    assign last_chunk = (next_chunk == burst_q);
    assign last_row   = (row_cnt == burst_num_q - BURST_W'(1));
    assign last_outer = (outer_cnt == outer_last_q);
    assign last_req   = last_chunk && last_row && last_outer;

    assign req_accept = ddr_addr_valid && ddr_addr_ready;
    // Beats with nothing outstanding are stray and ignored.
    assign beat_cnt   = beat_valid && beat_ready && (pending != '0);
    // The done cycle is already IDLE; holding off start there keeps one idle cycle between commands.
    assign start_acc  = (state == IDLE) && start && !done_q;

    // Accept adds at most req_size, which credit_ok already bounded by MAX_PEND_BEATS.
    always_comb begin
        pending_nxt = pending;
        if (req_accept) begin
            pending_nxt = pending_nxt + PEND_W'(req_size);
        end
        if (beat_cnt) begin
            pending_nxt = pending_nxt - PEND_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start_acc) begin
                    state_nxt = (burst == '0 || burst_num == '0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                if (req_accept && last_req) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pending_nxt == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    // pending only grows on accept, so once valid is up it stays up until accepted.
    always_comb begin
        busy           = (state != IDLE);
        ddr_addr_valid = (state == ISSUE) && credit_ok;
    end

    assign done     = done_q;
    assign ddr_addr = cur_addr;
    assign ddr_size = req_size;

    // ------------------------------------------------------------------
    // Datapath: command latch, address walk, credit counter, done pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_q      <= '0;
            burst_num_q  <= '0;
            outer_last_q <= '0;
            step_q       <= '0;
            outer_step_q <= '0;
            outer_base   <= '0;
            row_base     <= '0;
            cur_addr     <= '0;
            chunk_off    <= '0;
            row_cnt      <= '0;
            outer_cnt    <= '0;
            pending      <= '0;
            done_q       <= 1'b0;
        end else begin
            pending <= pending_nxt;
            done_q  <= (state == DRAIN) && (pending_nxt == '0);

            if (start_acc) begin
                burst_q      <= burst;
                burst_num_q  <= burst_num;
                outer_last_q <= (outer_num == '0) ? '0 : outer_num - BURST_W'(1);
                step_q       <= step;
                outer_step_q <= outer_step;
                outer_base   <= st_addr;
                row_base     <= st_addr;
                cur_addr     <= st_addr;
                chunk_off    <= '0;
                row_cnt      <= '0;
                outer_cnt    <= '0;
            end else if (req_accept) begin
                // Walk order: chunk within row, then row, then outer iteration.
                if (!last_chunk) begin
                    chunk_off <= next_chunk;
                    cur_addr  <= cur_addr + DDR_ADDR_W'(req_size);
                end else begin
                    chunk_off <= '0;
                    if (!last_row) begin
                        row_cnt  <= row_cnt + BURST_W'(1);
                        row_base <= row_base + step_q;
                        cur_addr <= row_base + step_q;
                    end else if (!last_outer) begin
                        row_cnt    <= '0;
                        outer_cnt  <= outer_cnt + BURST_W'(1);
                        outer_base <= outer_base + outer_step_q;
                        row_base   <= outer_base + outer_step_q;
                        cur_addr   <= outer_base + outer_step_q;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ddr_addr_gen_2d.sv
module tb_ddr_addr_gen_2d;

    localparam int AW   = 32;
    localparam int BW   = 8;
    localparam int MAXB = 16;
    localparam int MAXP = 32;
    localparam int BND  = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] st_addr;
    logic [BW-1:0] burst;
    logic [AW-1:0] step;
    logic [BW-1:0] burst_num;
    logic [BW-1:0] outer_num;
    logic [AW-1:0] outer_step;
    logic [AW-1:0] ddr_addr;
    logic [BW-1:0] ddr_size;
    logic          ddr_addr_valid;
    logic          ddr_addr_ready;
    logic          beat_valid;
    logic          beat_ready;

    always #5 clk = ~clk;

    ddr_addr_gen_2d #(
        .DDR_ADDR_W    (AW),
        .BURST_W       (BW),
        .MAX_BURST     (MAXB),
        .MAX_PEND_BEATS(MAXP),
        .BOUNDARY_BEATS(BND)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .st_addr       (st_addr),
        .burst         (burst),
        .step          (step),
        .burst_num     (burst_num),
        .outer_num     (outer_num),
        .outer_step    (outer_step),
        .ddr_addr      (ddr_addr),
        .ddr_size      (ddr_size),
        .ddr_addr_valid(ddr_addr_valid),
        .ddr_addr_ready(ddr_addr_ready),
        .beat_valid    (beat_valid),
        .beat_ready    (beat_ready)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    typedef struct {
        logic [AW-1:0] a;
        int            sz;
    } req_t;

    req_t exp_q[$];

    // Expected request list straight from the region description.
    task automatic build_reqs(input logic [AW-1:0] st, input int bu, input logic [AW-1:0] stp,
                              input int bn, input int on, input logic [AW-1:0] os);
        int on_eff;
        exp_q.delete();
        on_eff = (on == 0) ? 1 : on;
        for (int o = 0; o < on_eff; o++) begin
            for (int r = 0; r < bn; r++) begin
                int off;
                off = 0;
                while (off < bu) begin
                    req_t rq;
                    int   sz;
                    rq.a = st + os * AW'(o) + stp * AW'(r) + AW'(off);
                    sz   = bu - off;
                    if (sz > MAXB) sz = MAXB;
`ifdef DDR_ADDR_GEN_BOUNDARY_SPLIT_EN
                    begin
                        int room;
                        room = BND - int'(rq.a % BND);
                        if (sz > room) sz = room;
                    end
`endif
                    rq.sz = sz;
                    exp_q.push_back(rq);
                    off += sz;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rhold: ready forced low for the first rhold cycles; bhold: no beats for the first bhold cycles.
    // rmode 0: ready always 1, 1: random. bmode 0: prompt beats, 1: random (incl. stray beats).
    task automatic run_cmd(input logic [AW-1:0] st, input int bu, input logic [AW-1:0] stp,
                           input int bn, input int on, input logic [AW-1:0] os,
                           input int rhold, input int bhold, input int rmode, input int bmode);
        int pend;
        int cyc;
        bit exp_done;
        bit exp_v;
        bit finished;
        bit acc;
        bit bt;
        bit q_empty;
        build_reqs(st, bu, stp, bn, on, os);
        pend           = 0;
        ddr_addr_ready = 1'b0;
        beat_valid     = 1'b0;
        beat_ready     = 1'b0;
        st_addr        = st;
        burst          = BW'(bu);
        step           = stp;
        burst_num      = BW'(bn);
        outer_num      = BW'(on);
        outer_step     = os;
        start          = 1'b1;
        tick();
        start    = 1'b0;
        exp_done = 1'b0;
        finished = 1'b0;
        cyc      = 0;
        while (!finished && cyc < 5000) begin
            check_eq("done", done, exp_done);
            check_eq("busy", busy, !exp_done);
            if (exp_done) begin
                finished = 1'b1;
            end else begin
                exp_v = (exp_q.size() > 0) && (pend + exp_q[0].sz <= MAXP);
                check_eq("valid", ddr_addr_valid, exp_v);
                if (ddr_addr_valid && exp_q.size() > 0) begin
                    check_eq("addr", ddr_addr, exp_q[0].a);
                    check_eq("size", ddr_size, exp_q[0].sz);
                end
                if (cyc < rhold) ddr_addr_ready = 1'b0;
                else if (rmode == 0) ddr_addr_ready = 1'b1;
                else ddr_addr_ready = ($urandom_range(0, 3) != 0);
                if (cyc < bhold) begin
                    beat_valid = 1'b0;
                    beat_ready = 1'b1;
                end else if (bmode == 0) begin
                    beat_valid = (pend > 0);
                    beat_ready = 1'b1;
                end else begin
                    beat_valid = ($urandom_range(0, 2) != 0);
                    beat_ready = ($urandom_range(0, 3) != 0);
                end
                q_empty = (exp_q.size() == 0);
                acc     = exp_v && ddr_addr_ready;
                bt      = beat_valid && beat_ready && (pend > 0);
                if (acc) begin
                    pend += exp_q[0].sz;
                    void'(exp_q.pop_front());
                end
                if (bt) pend -= 1;
                exp_done = q_empty && (pend == 0);
                tick();
                cyc++;
            end
        end
        check_eq("completed_in_budget", finished, 1'b1);
        ddr_addr_ready = 1'b0;
        beat_valid     = 1'b0;
        tick();
        check_eq("done_one_cycle", done, 1'b0);
        check_eq("idle_after_done", busy, 1'b0);
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        st_addr        = '0;
        burst          = '0;
        step           = '0;
        burst_num      = '0;
        outer_num      = '0;
        outer_step     = '0;
        ddr_addr_ready = 1'b0;
        beat_valid     = 1'b0;
        beat_ready     = 1'b0;
        repeat (3) tick();
        check_eq("rst_busy",  busy, 1'b0);
        check_eq("rst_done",  done, 1'b0);
        check_eq("rst_valid", ddr_addr_valid, 1'b0);
        check_eq("rst_addr",  ddr_addr, 0);
        check_eq("rst_size",  ddr_size, 0);
        rst = 1'b0;
        tick();

        // Basic rows, chunking, outer loop, backpressure, credits, empty commands, boundary case
        run_cmd(32'h100, 4, 32'h10, 3, 1, 32'h0, 0, 0, 0, 0);
        run_cmd(32'h0, 40, 32'h0, 1, 1, 32'h0, 0, 0, 0, 0);
        run_cmd(32'h0, 40, 32'h0, 1, 2, 32'h1000, 0, 0, 0, 0);
        run_cmd(32'h200, 8, 32'h20, 2, 1, 32'h0, 5, 0, 0, 0);
        run_cmd(32'h300, 16, 32'h40, 4, 1, 32'h0, 0, 20, 0, 0);
        run_cmd(32'h400, 4, 32'h10, 0, 1, 32'h0, 0, 0, 0, 0);
        run_cmd(32'h400, 0, 32'h10, 3, 2, 32'h0, 0, 0, 0, 0);
        run_cmd(32'h3C, 16, 32'h0, 1, 1, 32'h0, 0, 0, 0, 0);
        run_cmd(32'hFFFF_FFF8, 20, 32'h4, 2, 0, 32'h0, 0, 0, 1, 1);

        // Reset in the middle of issuing
        st_addr = 32'h500; burst = 8'd4; step = 32'h10; burst_num = 8'd4;
        outer_num = 8'd1; outer_step = 32'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        ddr_addr_ready = 1'b1;
        check_eq("mid_valid0", ddr_addr_valid, 1'b1);
        tick();
        check_eq("mid_addr1", ddr_addr, 32'h510);
        tick();
        check_eq("mid_addr2", ddr_addr, 32'h520);
        ddr_addr_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_mid_valid", ddr_addr_valid, 1'b0);
        check_eq("rst_mid_busy",  busy, 1'b0);
        check_eq("rst_mid_done",  done, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_mid_no_done", done, 1'b0);
        end
        run_cmd(32'h700, 6, 32'h8, 2, 1, 32'h0, 0, 0, 0, 0);

        // Randomized commands with random ready and beat return
        for (int k = 0; k < 25; k++) begin
            logic [AW-1:0] r_st;
            logic [AW-1:0] r_stp;
            logic [AW-1:0] r_os;
            r_st  = $urandom();
            r_stp = $urandom_range(0, 255);
            r_os  = $urandom();
            run_cmd(r_st, $urandom_range(0, 24), r_stp, $urandom_range(0, 3),
                    $urandom_range(0, 3), r_os, $urandom_range(0, 3), $urandom_range(0, 6),
                    $urandom_range(0, 1), $urandom_range(0, 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
